sram_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and access sequencer for the generic async SRAM
//  (active-low ce/oe/we, shared tri-state data bus). Converts valid/ready requests

---
 rtl/sram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and access sequencer for a generic async SRAM.
// Registered strobes, setup/access/hold phases, one access in flight.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_adr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    ce,
  output logic                    oe,
  output logic                    we,
  output logic [ADDR_WIDTH-1:0]   adr,
  inout  wire  [DATA_WIDTH-1:0]   data
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  ce_q, ce_d;
  logic                  oe_q, oe_d;
  logic                  we_q, we_d;
  logic                  drv_q, drv_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  gnt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    adr_d       = adr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = 2'b00;
    req_ready   = 2'b00;
    gnt         = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gnt = (req_valid == 2'b11) ? ~last_q : req_valid[1];
          req_ready[gnt] = 1'b1;
          owner_d = gnt;
          last_d  = gnt;
          write_d = gnt ? req_write[1] : req_write[0];
          adr_d   = gnt ? req_adr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                        : req_adr[ADDR_WIDTH-1:0];
          wdata_d = gnt ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                        : req_wdata[DATA_WIDTH-1:0];
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CW'(WAIT_CYCLES - 1);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          if (!write_q) rsp_rdata_d = data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes decode the next state so the pins come straight from flops.
    ce_d  = (state_d == IDLE);
    oe_d  = !((state_d == ACCESS) && !write_d);
    we_d  = !((state_d == ACCESS) && write_d);
    drv_d = (state_d != IDLE) && write_d;
    if (state_d == HOLD) rsp_valid_d[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      adr_q       <= '0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      drv_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      adr_q       <= adr_d;
      ce_q        <= ce_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      drv_q       <= drv_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ce        = ce_q;
  assign oe        = oe_q;
  assign we        = we_q;
  assign adr       = adr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign data      = drv_q ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural SRAM.
// Second instance exercises a three-cycle strobe.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1, w0, w1;
  logic [7:0]  a0, a1;
  logic [15:0] d0, d1;
  logic [1:0]  req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic        ce, oe, we;
  logic [7:0]  adr;
  wire  [15:0] data;

  logic        v3;
  logic [1:0]  rdy3, rsp3;
  logic [15:0] rdata3;
  logic        ce3, oe3, we3;
  logic [7:0]  adr3;
  wire  [15:0] data3;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  own;
    logic        rd;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  int   owners[$];

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid({v1, v0}), .req_ready(req_ready),
    .req_write({w1, w0}), .req_adr({a1, a0}), .req_wdata({d1, d0}),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ce(ce), .oe(oe), .we(we), .adr(adr), .data(data)
  );

  sram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid({1'b0, v3}), .req_ready(rdy3),
    .req_write(2'b01), .req_adr(16'h0034), .req_wdata(32'h0000_A5A5),
    .rsp_valid(rsp3), .rsp_rdata(rdata3),
    .ce(ce3), .oe(oe3), .we(we3), .adr(adr3), .data(data3)
  );

  assign data = (!ce && !oe) ? mem[adr] : 'z;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
    forever begin
      @(negedge clk);
      if (!ce && !we) mem[adr] = data;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Strobe widths, turnaround gap and response scoreboard.
  initial begin
    int we_run, oe_run, ce_run, ce_hi;
    exp_t e;
    we_run = 0; oe_run = 0; ce_run = 0; ce_hi = 1;
    forever begin
      @(negedge clk);
      if (reset) begin
        we_run = 0; oe_run = 0; ce_run = 0; ce_hi = 1;
      end else begin
        if (!we) we_run++;
        else if (we_run != 0) begin
          check("we_low_len", we_run, 1); we_run = 0;
        end
        if (!oe) oe_run++;
        else if (oe_run != 0) begin
          check("oe_low_len", oe_run, 1); oe_run = 0;
        end
        if (!ce) begin
          if (ce_run == 0) check("idle_gap", 32'(ce_hi >= 1), 1);
          ce_run++; ce_hi = 0;
          check("oe_we_excl", 32'(!oe && !we), 0);
        end else begin
          if (ce_run != 0) check("ce_low_len", ce_run, 3);
          ce_run = 0; ce_hi++;
        end
        if (rsp_valid != 2'b00) begin
          if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 0);
          else begin
            e = sb.pop_front();
            check("rsp_owner", rsp_valid, e.own);
            check("rsp_cycle", cyc, e.cyc);
            if (e.rd) check("rsp_rdata", rsp_rdata, e.rdata);
            owners.push_back(rsp_valid[1] ? 1 : 0);
          end
        end
      end
    end
  end

  initial begin
    int we_run, ce_run;
    we_run = 0; ce_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        we_run = 0; ce_run = 0;
      end else begin
        if (!we3) we_run++;
        else if (we_run != 0) begin
          check("w3_we_low_len", we_run, 3); we_run = 0;
        end
        if (!ce3) begin
          ce_run++;
          check("w3_adr_stable", adr3, 8'h34);
          check("w3_data_stable", data3, 16'hA5A5);
        end else if (ce_run != 0) begin
          check("w3_ce_low_len", ce_run, 5); ce_run = 0;
        end
      end
    end
  end

  task automatic req(input bit i, input bit wr, input logic [7:0] a,
                     input logic [15:0] d, input bit push);
    int   n;
    exp_t e;
    @(negedge clk);
    if (i) begin v1 = 1'b1; w1 = wr; a1 = a; d1 = d; end
    else begin v0 = 1'b1; w0 = wr; a0 = a; d0 = d; end
    #1;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      check("hs_timeout", 0, 1);
      if (i) v1 = 1'b0; else v0 = 1'b0;
      return;
    end
    if (push) begin
      e.own   = i ? 2'b10 : 2'b01;
      e.rd    = !wr;
      e.rdata = ref_mem[a];
      e.cyc   = cyc + 3;
      sb.push_back(e);
    end
    if (wr) ref_mem[a] = d;
    @(posedge clk); #1;
    if (i) v1 = 1'b0; else v0 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) check("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c, n;
    for (int k = 0; k < 256; k++) ref_mem[k] = 16'h1000 + 16'(k);
    reset = 1'b1;
    v0 = 0; v1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; v3 = 0;
    repeat (2) @(negedge clk);
    check("rst_ce", ce, 1);
    check("rst_oe", oe, 1);
    check("rst_we", we, 1);
    check("rst_adr", adr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_ready", req_ready, 0);
    reset = 1'b0;

    req(0, 1, 8'h12, 16'hBEEF, 1);
    drain();
    req(1, 0, 8'h12, 16'h0000, 1);
    drain();

    @(negedge clk);
    v3 = 1'b1; #1;
    n = 0;
    while (!rdy3[0] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("w3_ready", rdy3, 2'b01);
    c = cyc;
    @(posedge clk); #1; v3 = 1'b0;
    n = 0;
    while (rsp3 == 2'b00 && n < 20) begin
      @(negedge clk); n++;
    end
    check("w3_rsp", rsp3, 2'b01);
    check("w3_latency", cyc - c, 5);
    repeat (3) @(negedge clk);

    fork
      req(0, 0, 8'h12, 16'h0000, 1);
      req(1, 1, 8'h20, 16'h1234, 1);
    join
    drain();
    req(0, 0, 8'h20, 16'h0000, 1);
    drain();

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    owners.delete();
    fork
      begin
        req(0, 0, 8'h01, 16'h0000, 1);
        req(0, 0, 8'h01, 16'h0000, 1);
      end
      begin
        req(1, 0, 8'h02, 16'h0000, 1);
        req(1, 0, 8'h02, 16'h0000, 1);
      end
    join
    drain();
    check("rr_count", owners.size(), 4);
    for (int k = 0; k < owners.size() && k < 4; k++)
      check("rr_order", owners[k], k % 2);

    req(0, 0, 8'h12, 16'h0000, 0);
    @(negedge clk);
    @(negedge clk);
    check("mid_oe_low", oe, 0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_ce", ce, 1);
    check("mid_rst_oe", oe, 1);
    check("mid_rst_we", we, 1);
    check("mid_rst_rsp", rsp_valid, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    req(1, 0, 8'h12, 16'h0000, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
